// File: rtl/uart_rx.sv
// UART receive engine: oversampled 8N1-style frame recovery with a valid/ready word port.
// Mid-bit sampling from a half-bit start check; framing and overrun errors pulse for one clk.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic [DATA_BITS-1:0] sh, sh_nxt;
    logic                 rx_meta, rx_s;
    logic                 word_done, stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            sh    <= sh_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sh_nxt    = sh;
        word_done = 1'b0;
        stop_bad  = 1'b0;
        if (sample_tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_nxt = S_START;
                        cnt_nxt   = '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (rx_s) begin
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_DATA;
                            cnt_nxt   = '0;
                            idx_nxt   = '0;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        sh_nxt  = {rx_s, sh[DATA_BITS-1:1]};
                        cnt_nxt = '0;
                        idx_nxt = idx + IW'(1);
                        if (idx == LAST_IDX) begin
                            state_nxt = S_STOP;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt_nxt = '0;
                        if (rx_s) begin
                            word_done = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            stop_bad  = 1'b1;
                            state_nxt = S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A word arriving while the previous one is still pending is dropped, unless
    // the sink takes the old one in this very cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= stop_bad;
            overrun_err <= 1'b0;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= sh;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames, checked against an expected-word queue.
// Expected words and error counts come from what the bench sends, not from the DUT.
module tb_uart_rx;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 27;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic          rxd = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun_err;

    int n_vec = 0;
    int n_err = 0;
    int n_ferr = 0, n_ovr = 0, n_vcyc = 0, n_both = 0;
    int f0, o0, v0;
    bit tick_cont = 1'b0;
    int ready_mode = 0;  // 0 low, 1 high, 2 random
    logic [DB-1:0] got_q[$];
    logic [DB-1:0] exp_q[$];

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_tick(sample_tick),
        .rxd(rxd),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun_err(overrun_err)
    );

    always #10 clk = ~clk;

    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #2;
            if (tick_cont) begin
                sample_tick = 1'b1;
            end else begin
                sample_tick = (div == TICK_DIV - 1);
                div = (div == TICK_DIV - 1) ? 0 : div + 1;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) n_ferr++;
            if (overrun_err) n_ovr++;
            if (frame_err && overrun_err) n_both++;
            if (rx_valid) n_vcyc++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int bit_clks();
        return tick_cont ? OS : OS * TICK_DIV;
    endfunction

    task automatic line(input logic v, input int nbits);
        rxd = v;
        step(nbits * bit_clks());
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_val);
        line(1'b0, 1);
        for (int i = 0; i < DB; i++) line(d[i], 1);
        line(stop_val, 1);
    endtask

    task automatic snap();
        f0 = n_ferr;
        o0 = n_ovr;
        v0 = n_vcyc;
    endtask

    task automatic check_words(input string tag);
        int t;
        logic [DB-1:0] g, e;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 5000) begin
            step(1);
            t++;
        end
        check_eq({tag, " word count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_eq({tag, " word"}, 32'(g), 32'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin : main
        logic [DB-1:0] d;
        logic bad;
        int nbad;

        rst_n = 1'b0;
        step(3);
        check_eq("reset rx_valid", 32'(rx_valid), 0);
        check_eq("reset rx_data", 32'(rx_data), 0);
        check_eq("reset frame_err", 32'(frame_err), 0);
        check_eq("reset overrun_err", 32'(overrun_err), 0);
        rst_n = 1'b1;
        step(5);

        // single frame, sink always ready
        ready_mode = 1;
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        line(1'b1, 1);
        check_words("a5");
        check_eq("a5 valid cycles", 32'(n_vcyc - v0), 1);
        check_eq("a5 frame_err", 32'(n_ferr - f0), 0);
        check_eq("a5 overrun_err", 32'(n_ovr - o0), 0);

        // short low glitch must be rejected
        snap();
        rxd = 1'b0;
        step(4 * TICK_DIV);
        line(1'b1, 2);
        check_eq("glitch valid cycles", 32'(n_vcyc - v0), 0);
        check_eq("glitch frame_err", 32'(n_ferr - f0), 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        line(1'b1, 1);
        check_words("after glitch");

        // bad stop bit followed by a long break
        snap();
        send_frame(8'h3C, 1'b0);
        line(1'b0, 20);
        check_eq("break frame_err", 32'(n_ferr - f0), 1);
        check_eq("break valid cycles", 32'(n_vcyc - v0), 0);
        line(1'b1, 2);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        line(1'b1, 1);
        check_words("after break");
        check_eq("after break frame_err", 32'(n_ferr - f0), 1);

        // overrun: sink stalled for two frames
        ready_mode = 0;
        step(2);
        snap();
        send_frame(8'h11, 1'b1);
        line(1'b1, 1);
        send_frame(8'h22, 1'b1);
        line(1'b1, 1);
        check_eq("overrun rx_data", 32'(rx_data), 32'h11);
        check_eq("overrun rx_valid", 32'(rx_valid), 1);
        check_eq("overrun pulses", 32'(n_ovr - o0), 1);
        check_eq("overrun frame_err", 32'(n_ferr - f0), 0);
        exp_q.push_back(8'h11);
        ready_mode = 1;
        step(1);
        @(negedge clk);
        check_eq("consume valid before", 32'(rx_valid), 1);
        @(negedge clk);
        check_eq("consume valid after", 32'(rx_valid), 0);
        check_eq("consume data held", 32'(rx_data), 32'h11);
        step(1);
        check_words("overrun");

        // asynchronous reset during data bit 4
        d = 8'h5A;
        line(1'b0, 1);
        for (int i = 0; i < 4; i++) line(d[i], 1);
        rxd = d[4];
        step(bit_clks() / 2);
        rst_n = 1'b0;
        #1;
        check_eq("midreset rx_data", 32'(rx_data), 0);
        check_eq("midreset rx_valid", 32'(rx_valid), 0);
        check_eq("midreset frame_err", 32'(frame_err), 0);
        check_eq("midreset overrun_err", 32'(overrun_err), 0);
        rxd = 1'b1;
        step(3);
        rst_n = 1'b1;
        line(1'b1, 2);
        snap();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        line(1'b1, 1);
        check_words("after reset");
        check_eq("after reset frame_err", 32'(n_ferr - f0), 0);

        // back-to-back frames with single stop bits
        snap();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        line(1'b1, 1);
        check_words("b2b");
        check_eq("b2b valid cycles", 32'(n_vcyc - v0), 3);
        check_eq("b2b frame_err", 32'(n_ferr - f0), 0);
        check_eq("b2b overrun_err", 32'(n_ovr - o0), 0);

        // randomized frames, continuous tick, random sink back-pressure
        tick_cont = 1'b1;
        ready_mode = 2;
        step(4);
        snap();
        nbad = 0;
        for (int n = 0; n < 40; n++) begin
            d = DB'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rxd = 1'b0;
                step($urandom_range(1, 5));
                line(1'b1, 2);
            end
            send_frame(d, !bad);
            if (bad) nbad++;
            else exp_q.push_back(d);
            line(1'b1, $urandom_range(1, 3));
        end
        line(1'b1, 2);
        check_words("random");
        check_eq("random frame_err", 32'(n_ferr - f0), 32'(nbad));
        check_eq("random overrun_err", 32'(n_ovr - o0), 0);
        check_eq("errors coincident", 32'(n_both), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
